nco_phase_accumulator: RTL and testbench
========================================

NCO_PHASE_ACCUMULATOR -- requirements
Module: nco_phase_accumulator

Interface
REQ-001: Parameter ACC_WIDTH, default 24, is the accumulator and frequency-word width in bits.
REQ-002: Parameter OUT_WIDTH, default 12, is the output phase width in bits; OUT_WIDTH <= ACC_WIDTH SHALL hold.
REQ-003: Parameter DIV_WIDTH, default 8, is the sample-rate divider width in bits.
REQ-004: clk  input  1  rising-edge clock for all state.
REQ-005: reset_n  input  1  synchronous, active-low reset.
REQ-006: en  input  1  run enable; when 0, all state holds.
REQ-007: div  input  DIV_WIDTH  sample divider; one tick every div+1 enabled clocks.
REQ-008: fword_valid  input  1  new frequency word offered.
REQ-009: fword_data  input  ACC_WIDTH  new frequency (phase increment) word.
REQ-010: fword_ready  output  1  pending slot empty; combinational, equal to NOT pending_valid.
REQ-011: fword_active  output  ACC_WIDTH  increment currently in use.
REQ-012: phase_out  output  OUT_WIDTH  accumulator bits [ACC_WIDTH-1 : ACC_WIDTH-OUT_WIDTH]; feeds the downstream freeze stage data input.
REQ-013: sample_stb  output  1  one-clock pulse marking a new phase_out; drives the freeze stage s input.
REQ-014: wrap  output  1  one-clock pulse, coincident with sample_stb, when the update overflowed.

Function
REQ-015: Prescaler cnt SHALL count 0..div on enabled clocks; tick when en=1 and cnt >= div, then cnt <= 0; otherwise cnt <= cnt+1.
REQ-016: A div decrease below the current cnt SHALL produce a tick on the next enabled clock (>= compare), never a cnt wrap through 2^DIV_WIDTH.
REQ-017: div=0 SHALL produce a tick on every enabled clock.
REQ-018: On tick, acc <= (acc + fword_active) mod 2^ACC_WIDTH; carry-out is the wrap condition.
REQ-019: sample_stb and wrap SHALL be registered and high in the same cycle the updated acc is visible on phase_out (1-clock latency from tick).
REQ-020: With en=0: cnt, acc, fword_active held; sample_stb=0, wrap=0; phase_out unchanged.
REQ-021: Handshake: transfer when fword_valid=1 and fword_ready=1; fword_data is captured into the pending register and pending_valid <= 1.
REQ-022: fword_valid with fword_ready=0 SHALL be ignored; the source holds data until ready.
REQ-023: The pending word SHALL be applied (fword_active <= pending, pending_valid <= 0) on: (a) a tick whose addition wraps; (b) any tick while fword_active = 0; (c) any clock while en = 0.
REQ-024: The applying addition SHALL use the old fword_active; the new word takes effect from the next tick.
REQ-025: Transfer and apply cannot coincide, because ready=0 while pending; fword_ready SHALL rise the clock after the apply.
REQ-026: fword_active = 0 SHALL hold acc constant on ticks while sample_stb still pulses.

Reset
REQ-027: While reset_n=0 at a clock edge: acc=0, cnt=0, fword_active=0, pending_valid=0, phase_out=0, sample_stb=0, wrap=0.
REQ-028: Reset SHALL override en, tick and handshake; a transfer offered during a reset cycle SHALL be discarded.
REQ-029: fword_ready SHALL read 1 in the first cycle after reset release.

Verification
REQ-030: Reset, div=0, en=1, load 0x100000 -> applied at the first tick (active=0); phase_out then steps 0x100, 0x200, ... per clock; wrap pulses with phase_out=0x000 on the 16th update.
REQ-031: div=3, active 0x010000 -> sample_stb exactly every 4th clock; phase_out steps by 0x010 per strobe.
REQ-032: active=0x400000, acc=0x400000; load 0x100000 -> phase_out 0x800, 0xC00, 0x000 (wrap, apply), 0x100, 0x200; fword_ready is 0 from transfer until the clock after the wrap.
REQ-033: Two back-to-back valid words with no wrap pending -> first accepted; ready=0 holds off the second until the apply; the second is accepted the following cycle.
REQ-034: en=0 for 10 clocks mid-run with a word pending -> no strobes, phase_out frozen, pending applied on the first en=0 clock; on resume the next tick uses the new word.
REQ-035: reset_n=0 for one clock mid-count with pending_valid=1 -> all outputs 0, pending dropped, fword_ready=1 next cycle.

Source files
------------

// File: rtl/nco_phase_accumulator.sv
// NCO phase accumulator with prescaled tick and
// a one-deep frequency-word slot applied at safe points.
module nco_phase_accumulator #(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 12,
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 fword_valid,
    input  logic [ACC_WIDTH-1:0] fword_data,
    output logic                 fword_ready,
    output logic [ACC_WIDTH-1:0] fword_active,
    output logic [OUT_WIDTH-1:0] phase_out,
    output logic                 sample_stb,
    output logic                 wrap
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] active_q, active_d;
    logic [ACC_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 stb_q, stb_d;
    logic                 wrap_q, wrap_d;

    logic                 tick;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic                 apply;
    logic                 xfer;

    // Next-state: prescaler, accumulator, word slot, strobes
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        stb_d      = 1'b0;
        wrap_d     = 1'b0;

        // >= compare so a shrinking div never lets cnt run away
        tick  = en && (cnt_q >= div);
        sum   = {1'b0, acc_q} + {1'b0, active_q};
        carry = sum[ACC_WIDTH];

        // Swap only where it cannot glitch the phase sequence
        apply = pend_vld_q
              && (!en || (tick && (carry || active_q == '0)));
        xfer  = fword_valid && !pend_vld_q;

        if (en) begin
            if (tick) cnt_d = '0;
            else      cnt_d = cnt_q + 1'b1;
        end

        if (tick) begin
            acc_d  = sum[ACC_WIDTH-1:0];
            stb_d  = 1'b1;
            wrap_d = carry;
        end

        if (apply) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
        end else if (xfer) begin
            pend_d     = fword_data;
            pend_vld_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            stb_q      <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            stb_q      <= stb_d;
            wrap_q     <= wrap_d;
        end
    end

    assign fword_ready  = ~pend_vld_q;
    assign fword_active = active_q;
    assign phase_out    = acc_q[ACC_WIDTH-1 -: OUT_WIDTH];
    assign sample_stb   = stb_q;
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
// Directed bench for nco_phase_accumulator with an
// expectation queue popped after each clock.
module tb_nco_phase_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [7:0]  div;
    logic        fword_valid;
    logic [23:0] fword_data;
    logic        fword_ready;
    logic [23:0] fword_active;
    logic [11:0] phase_out;
    logic        sample_stb;
    logic        wrap;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string      tag;
        logic [11:0] ph;
        logic        stb;
        logic        wr;
        logic        rdy;
    } exp_t;

    exp_t sb[$];

    nco_phase_accumulator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (en),
        .div          (div),
        .fword_valid  (fword_valid),
        .fword_data   (fword_data),
        .fword_ready  (fword_ready),
        .fword_active (fword_active),
        .phase_out    (phase_out),
        .sample_stb   (sample_stb),
        .wrap         (wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: timeout reached, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk1(string tag, string f, logic [11:0] act, logic [11:0] ex);
        tests++;
        assert (act === ex) else begin
            fails++;
            $error("FAIL %s.%s: got %h required %h", tag, f, act, ex);
        end
    endtask

    // Push expectation, run one clock, pop and compare
    task automatic step(string tag, logic [11:0] ph,
                        logic stb, logic wr, logic rdy);
        exp_t e;
        exp_t p;
        e.tag = tag; e.ph = ph; e.stb = stb; e.wr = wr; e.rdy = rdy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        chk1(p.tag, "phase", phase_out, p.ph);
        chk1(p.tag, "stb", {11'd0, sample_stb}, {11'd0, p.stb});
        chk1(p.tag, "wrap", {11'd0, wrap}, {11'd0, p.wr});
        chk1(p.tag, "ready", {11'd0, fword_ready}, {11'd0, p.rdy});
    endtask

    initial begin
        reset_n     = 1'b0;
        en          = 1'b1;
        div         = 8'd0;
        fword_valid = 1'b1;
        fword_data  = 24'h123456;

        // reset with a transfer offered: must be discarded
        step("rst0", 12'h000, 0, 0, 1);
        step("rst1", 12'h000, 0, 0, 1);
        tests++;
        assert (fword_active === 24'h0) else begin
            fails++;
            $error("FAIL rst_active: got %h required %h", fword_active, 24'h0);
        end

        // basic run, div=0, load 0x100000
        reset_n     = 1'b1;
        fword_data  = 24'h100000;
        step("ld_xfer", 12'h000, 1, 0, 0);
        fword_valid = 1'b0;
        step("ld_apply", 12'h000, 1, 0, 1);
        tests++;
        assert (fword_active === 24'h100000) else begin
            fails++;
            $error("FAIL apply_active: got %h required %h", fword_active, 24'h100000);
        end
        for (int k = 1; k <= 16; k++)
            step("run16", 12'((k * 'h100) & 'hFFF), 1, (k == 16), 1);

        // load 0x010000 via en=0 path
        en          = 1'b0;
        fword_valid = 1'b1;
        fword_data  = 24'h010000;
        step("en0_xfer", 12'h000, 0, 0, 0);
        fword_valid = 1'b0;
        step("en0_apply", 12'h000, 0, 0, 1);

        // div=3: strobe every 4th clock
        en  = 1'b1;
        div = 8'd3;
        for (int i = 0; i < 12; i++)
            step("div3", 12'('h010 * ((i + 1) / 4)), (i % 4 == 3), 0, 1);

        // div decrease below cnt forces tick next clock
        step("dec_a", 12'h030, 0, 0, 1);
        step("dec_b", 12'h030, 0, 0, 1);
        div = 8'd1;
        step("dec_tick", 12'h040, 1, 0, 1);

        // reset mid-count with pending word
        div         = 8'd3;
        fword_valid = 1'b1;
        fword_data  = 24'h400000;
        step("pend_xfer", 12'h040, 0, 0, 0);
        fword_valid = 1'b0;
        step("pend_hold", 12'h040, 0, 0, 0);
        reset_n = 1'b0;
        step("mid_rst", 12'h000, 0, 0, 1);
        reset_n = 1'b1;
        div     = 8'd0;
        step("post_rst0", 12'h000, 1, 0, 1);
        step("post_rst1", 12'h000, 1, 0, 1);

        // set active=0x400000, acc=0x400000
        en          = 1'b0;
        fword_valid = 1'b1;
        fword_data  = 24'h400000;
        step("q_xfer", 12'h000, 0, 0, 0);
        fword_valid = 1'b0;
        step("q_apply", 12'h000, 0, 0, 1);
        en = 1'b1;
        step("q_acc", 12'h400, 1, 0, 1);

        // load 0x100000 while running; applied at wrap
        fword_valid = 1'b1;
        fword_data  = 24'h100000;
        step("w_800", 12'h800, 1, 0, 0);
        fword_valid = 1'b0;
        step("w_C00", 12'hC00, 1, 0, 0);
        step("w_000", 12'h000, 1, 1, 1);
        step("w_100", 12'h100, 1, 0, 1);
        step("w_200", 12'h200, 1, 0, 1);

        // back-to-back words: second held off until apply
        fword_valid = 1'b1;
        fword_data  = 24'h080000;
        step("bb_xfer1", 12'h300, 1, 0, 0);
        fword_data  = 24'h040000;
        for (int i = 1; i <= 12; i++)
            step("bb_run", 12'('h300 + 'h100 * i), 1, 0, 0);
        step("bb_wrap", 12'h000, 1, 1, 1);
        step("bb_xfer2", 12'h080, 1, 0, 0);
        fword_valid = 1'b0;
        step("bb_step", 12'h100, 1, 0, 0);

        // en=0 for 10 clocks: frozen, pending applied
        en = 1'b0;
        for (int i = 0; i < 10; i++)
            step("freeze", 12'h100, 0, 0, 1);
        tests++;
        assert (fword_active === 24'h040000) else begin
            fails++;
            $error("FAIL freeze_active: got %h required %h", fword_active, 24'h040000);
        end
        en = 1'b1;
        step("resume0", 12'h140, 1, 0, 1);
        step("resume1", 12'h180, 1, 0, 1);

        tests++;
        assert (sb.size() === 0) else begin
            fails++;
            $error("FAIL sb_empty: got %0d required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
